nios2_secure_memory_mem_guard: RTL

Arbiter, access filter and zeroization sequencer for the second port (s2) of the secure on-chip RAM. It shares the single memory port between a trusted master (m0) and an untrusted master (m1), and blocks m1 from a programmable protected word window. On command, it wipes that window with zeros while both masters are stalled.

---
 rtl/nios2_secure_memory_mem_guard_if.sv | 39 +++
 rtl/nios2_secure_memory_mem_guard.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/nios2_secure_memory_mem_guard_if.sv
// ---------------------------------------------------------------------------
// nios2_secure_memory_mem_guard_if
//
// One Avalon-MM style word port as seen between a bus master and the
// secure-RAM guard. The guard has two of these, one per master.
//
// Signals:
//   address       master -> slave  ADDR_W    word address
//   read          master -> slave  1         read request
//   write         master -> slave  1         write request (never with read)
//   writedata     master -> slave  DATA_W    write data
//   byteenable    master -> slave  DATA_W/8  byte lanes
//   waitrequest   slave -> master  1         stall (combinational)
//   readdata      slave -> master  DATA_W    read data
//   readdatavalid slave -> master  1         read data valid
// ---------------------------------------------------------------------------
interface nios2_secure_memory_mem_guard_if #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32
) ();
    logic [ADDR_W-1:0]   address;
    logic                read;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic                waitrequest;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata, readdatavalid
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata, readdatavalid
    );
endinterface

// File: rtl/nios2_secure_memory_mem_guard.sv
// ---------------------------------------------------------------------------
// nios2_secure_memory_mem_guard
//
// Arbiter, access filter and zeroization sequencer for port s2 of the
// secure on-chip RAM. A trusted master (m0) and an untrusted master (m1)
// share the single RAM port with round-robin arbitration. m1 accesses that
// fall inside the protected window [prot_lo, prot_hi] are granted but not
// forwarded: writes are dropped, reads return zero, and viol pulses. On
// zero_start the window (clamped to the RAM depth) is overwritten with
// zeros, one word per cycle, while both masters are stalled.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   m0, m1              slave side of each master's bus interface
//   mem_*               RAM port (readdata valid 1 cycle after a read)
//   prot_lo, prot_hi    protected window, inclusive, quasi-static
//   zero_start          pulse requesting a wipe of the window
//   zero_busy           wipe in progress
//   zero_done           1-cycle pulse when a wipe completes
//   viol, viol_addr     denied-m1-access pulse and its address
// ---------------------------------------------------------------------------
module nios2_secure_memory_mem_guard #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 5120
) (
    input  logic                  clk,
    input  logic                  reset,

    nios2_secure_memory_mem_guard_if.slave m0,
    nios2_secure_memory_mem_guard_if.slave m1,

    output logic [ADDR_W-1:0]     mem_address,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic [DATA_W-1:0]     mem_writedata,
    input  logic [DATA_W-1:0]     mem_readdata,

    input  logic [ADDR_W-1:0]     prot_lo,
    input  logic [ADDR_W-1:0]     prot_hi,
    input  logic                  zero_start,
    output logic                  zero_busy,
    output logic                  zero_done,
    output logic                  viol,
    output logic [ADDR_W-1:0]     viol_addr
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] ZERO = 1'b1;

    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH - 1);

    logic [0:0]        state;
    logic              last_grant;   // 1: m1 was granted most recently
    logic [ADDR_W-1:0] counter;
    logic [ADDR_W-1:0] wipe_hi;

    logic              tag_valid;
    logic              tag_master;   // 1: outstanding read belongs to m1
    logic              tag_denied;

    logic              req0;
    logic              req1;
    logic              grant0;
    logic              grant1;
    logic              deny1;
    logic [ADDR_W-1:0] hi_clamped;

    assign req0 = m0.read | m0.write;
    assign req1 = m1.read | m1.write;

    // An inverted window (lo > hi) can never satisfy both bounds, so it
    // naturally denies nothing.
    assign deny1 = (m1.address >= prot_lo) && (m1.address <= prot_hi);

    // Clamping the wipe end to the last real word keeps the counter from
    // ever having to step past DEPTH-1, so it cannot wrap.
    assign hi_clamped = (prot_hi > MAX_ADDR) ? MAX_ADDR : prot_hi;

    // Round-robin grant: on a tie the master that was not granted last
    // wins. No grants are made while the wipe owns the port.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE) begin
            grant0 = req0 && (!req1 || last_grant);
            grant1 = req1 && (!req0 || !last_grant);
        end
    end

    assign m0.waitrequest = req0 & ~grant0;
    assign m1.waitrequest = req1 & ~grant1;
    assign zero_busy      = (state == ZERO);

    // RAM port mux: the wipe sequencer, the granted master, or nothing.
    // A denied m1 access is granted to its master but never reaches RAM.
    always_comb begin
        mem_address    = '0;
        mem_chipselect = 1'b0;
        mem_write      = 1'b0;
        mem_byteenable = '0;
        mem_writedata  = '0;
        if (state == ZERO) begin
            mem_address    = counter;
            mem_chipselect = 1'b1;
            mem_write      = 1'b1;
            mem_byteenable = '1;
        end else if (grant0) begin
            mem_address    = m0.address;
            mem_chipselect = 1'b1;
            mem_write      = m0.write;
            mem_byteenable = m0.byteenable;
            mem_writedata  = m0.writedata;
        end else if (grant1 && !deny1) begin
            mem_address    = m1.address;
            mem_chipselect = 1'b1;
            mem_write      = m1.write;
            mem_byteenable = m1.byteenable;
            mem_writedata  = m1.writedata;
        end
    end

    // Read return is steered by the one-deep tag; the RAM data is only
    // exposed to the master that issued the read, and never for a denied one.
    assign m0.readdatavalid = tag_valid & ~tag_master;
    assign m1.readdatavalid = tag_valid &  tag_master;
    assign m0.readdata = (tag_valid && !tag_master && !tag_denied) ? mem_readdata : '0;
    assign m1.readdata = (tag_valid &&  tag_master && !tag_denied) ? mem_readdata : '0;

    // Arbitration history, read tag and violation reporting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant <= 1'b1;
            tag_valid  <= 1'b0;
            tag_master <= 1'b0;
            tag_denied <= 1'b0;
            viol       <= 1'b0;
            viol_addr  <= '0;
        end else begin
            if (grant0 || grant1) begin
                last_grant <= grant1;
            end
            tag_valid  <= (grant0 && m0.read) || (grant1 && m1.read);
            tag_master <= grant1;
            tag_denied <= grant1 && deny1;
            viol       <= grant1 && deny1;
            if (grant1 && deny1) begin
                viol_addr <= m1.address;
            end
        end
    end

    // Wipe sequencer. zero_start is only looked at in IDLE; an empty
    // window completes immediately with a done pulse and no writes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            counter   <= '0;
            wipe_hi   <= '0;
            zero_done <= 1'b0;
        end else begin
            zero_done <= 1'b0;
            if (state == IDLE) begin
                if (zero_start) begin
                    if (prot_lo <= hi_clamped) begin
                        state   <= ZERO;
                        counter <= prot_lo;
                        wipe_hi <= hi_clamped;
                    end else begin
                        zero_done <= 1'b1;
                    end
                end
            end else begin
                counter <= counter + ADDR_W'(1);
                if (counter == wipe_hi) begin
                    state     <= IDLE;
                    zero_done <= 1'b1;
                end
            end
        end
    end

endmodule
